// File: rtl/div_iter_pkg.sv
// Shared execute-stage definitions for the iterative divider: operand width,
// FSM state encoding and the ALU op codes the decoder uses to request a divide.
package div_iter_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_BUSY   = 2'd2,
        DIV_DONE   = 2'd3
    } div_state_t;

    // ALU op codes (SPECIAL funct field) that map onto start_i/signed_i.
    localparam logic [5:0] ALU_DIV  = 6'h1A;
    localparam logic [5:0] ALU_DIVU = 6'h1B;

    // Decoder helper: the signed flag that accompanies a divide op.
    function automatic logic div_op_signed(input logic [5:0] op);
        return (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/result bundle between the E-stage decode and the divider.
// Handshake: the requester raises start_i with operands and holds it (and the
// operands) while stall_o is high; ready_o marks result_o valid, and the
// request is retired by dropping start_i for at least one cycle.
interface div_iter_if;
    import div_iter_pkg::*;

    logic                  start_i;
    logic                  signed_i;
    logic [DATA_W-1:0]     opa_i;
    logic [DATA_W-1:0]     opb_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stall_o;
    div_state_t            state_o;

    modport master (
        output start_i, signed_i, opa_i, opb_i, annul_i,
        input  result_o, ready_o, stall_o, state_o
    );

    modport slave (
        input  start_i, signed_i, opa_i, opb_i, annul_i,
        output result_o, ready_o, stall_o, state_o
    );
endinterface

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, trial-subtract
// the divisor from the widened remainder and restore on borrow.
module div_iter_step
    import div_iter_pkg::*;
(
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_div,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);
    logic [DATA_W:0] w_shift;
    logic [DATA_W:0] w_diff;

    // The remainder stays below the divisor, so bit DATA_W of the difference
    // is a clean borrow flag even when the shifted value exceeds DATA_W bits.
    assign w_shift = {i_rem, i_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, i_div};

    // Keep the difference when it is non-negative, otherwise restore.
    always_comb begin
        o_rem = w_shift[DATA_W-1:0];
        o_quo = {i_quo[DATA_W-2:0], 1'b0};
        if (!w_diff[DATA_W]) begin
            o_rem = w_diff[DATA_W-1:0];
            o_quo = {i_quo[DATA_W-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. Works on unsigned
// magnitudes for DATA_W iterations and applies the operand signs when the
// result is registered. Also produces the E-stage divide stall.
module div_iter
    import div_iter_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    div_iter_if.slave   bus
);
    div_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_rem;
    logic [DATA_W-1:0]     r_quo;
    logic [DATA_W-1:0]     r_div;
    logic                  r_qneg;
    logic                  r_rneg;
    logic [2*DATA_W-1:0]   r_result;
    logic                  r_ready;

    logic [DATA_W-1:0]     w_rem_nxt;
    logic [DATA_W-1:0]     w_quo_nxt;
    logic [DATA_W-1:0]     w_mag_a;
    logic [DATA_W-1:0]     w_mag_b;

    // Magnitudes of the operands; DIVU passes them through untouched.
    assign w_mag_a = (bus.signed_i && bus.opa_i[DATA_W-1]) ? -bus.opa_i : bus.opa_i;
    assign w_mag_b = (bus.signed_i && bus.opb_i[DATA_W-1]) ? -bus.opb_i : bus.opb_i;

    div_iter_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // Divider FSM: operand capture, iteration, sign fix-up and result hold.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= DIV_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    r_ready <= 1'b0;
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opb_i == '0) begin
                            r_state <= DIV_BYZERO;
                        end else begin
                            r_state <= DIV_BUSY;
                            r_cnt   <= '0;
                            r_rem   <= '0;
                            r_quo   <= w_mag_a;
                            r_div   <= w_mag_b;
                            r_qneg  <= bus.signed_i & (bus.opa_i[DATA_W-1] ^ bus.opb_i[DATA_W-1]);
                            r_rneg  <= bus.signed_i & bus.opa_i[DATA_W-1];
                        end
                    end
                end
                DIV_BYZERO: begin
                    if (bus.annul_i) begin
                        r_state <= DIV_IDLE;
                    end else begin
                        r_state  <= DIV_DONE;
                        r_result <= '0;
                        r_ready  <= 1'b1;
                    end
                end
                DIV_BUSY: begin
                    if (bus.annul_i) begin
                        r_state <= DIV_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            r_state  <= DIV_DONE;
                            r_ready  <= 1'b1;
                            r_result <= {(r_rneg ? -w_rem_nxt : w_rem_nxt),
                                         (r_qneg ? -w_quo_nxt : w_quo_nxt)};
                        end
                    end
                end
                DIV_DONE: begin
                    // Hold the result while E is stalled by something else.
                    if (bus.annul_i || !bus.start_i) begin
                        r_state  <= DIV_IDLE;
                        r_ready  <= 1'b0;
                        r_result <= '0;
                    end
                end
                default: begin
                    r_state <= DIV_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
    assign bus.stall_o  = bus.start_i & ~r_ready;
    assign bus.state_o  = r_state;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter with hand-computed quotient/remainder pairs.
module tb_div_iter;
    import div_iter_pkg::*;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    div_iter_if bus ();

    div_iter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide holding start_i until ready, then retire it.
    task automatic run_div(input string tag, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_res, input int exp_lat);
        int cycles;
        int stall_cycles;
        bus.start_i  = 1'b1;
        bus.signed_i = div_op_signed(op);
        bus.opa_i    = a;
        bus.opb_i    = b;
        #1;
        cycles       = 0;
        stall_cycles = bus.stall_o ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cycles++;
            if (bus.ready_o) break;
            if (bus.stall_o) stall_cycles++;
        end
        check({tag, " latency"}, 64'(cycles), 64'(exp_lat));
        check({tag, " stall_cycles"}, 64'(stall_cycles), 64'(exp_lat));
        check({tag, " result"}, bus.result_o, exp_res);
        check({tag, " stall_at_ready"}, 64'(bus.stall_o), 64'd0);
        bus.start_i = 1'b0;
        tick();
        check({tag, " ready_clear"}, 64'(bus.ready_o), 64'd0);
        check({tag, " result_clear"}, bus.result_o, 64'd0);
    endtask

    // Stimulus and checks
    initial begin
        int cycles;
        logic rose;
        n_checks     = 0;
        n_errors     = 0;
        resetn       = 1'b0;
        bus.start_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.opa_i    = '0;
        bus.opb_i    = '0;
        bus.annul_i  = 1'b0;
        tick();
        tick();
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset result", bus.result_o, 64'd0);
        check("reset state", 64'(bus.state_o), 64'(DIV_IDLE));
        check("reset stall", 64'(bus.stall_o), 64'd0);
        resetn = 1'b1;
        tick();

        run_div("divu_100_7", ALU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_div("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div("divu_m7_2", ALU_DIVU, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33);
        run_div("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
        run_div("div_m100_7", ALU_DIV, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
        run_div("divu_by0", ALU_DIVU, 32'd5, 32'd0, 64'd0, 2);

        // Annul in the middle of BUSY.
        bus.start_i  = 1'b1;
        bus.signed_i = 1'b0;
        bus.opa_i    = 32'h1234_5678;
        bus.opb_i    = 32'd3;
        for (int i = 0; i < 11; i++) tick();
        check("annul busy_state", 64'(bus.state_o), 64'(DIV_BUSY));
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        tick();
        bus.annul_i = 1'b0;
        check("annul idle", 64'(bus.state_o), 64'(DIV_IDLE));
        rose = bus.ready_o;
        for (int i = 0; i < 40; i++) begin
            tick();
            rose = rose | bus.ready_o;
        end
        check("annul no_ready", 64'(rose), 64'd0);
        check("annul result", bus.result_o, 64'd0);
        run_div("divu_9_3", ALU_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Reset in the middle of BUSY with start still held.
        bus.start_i  = 1'b1;
        bus.signed_i = 1'b0;
        bus.opa_i    = 32'd1000000;
        bus.opb_i    = 32'd7;
        for (int i = 0; i < 21; i++) tick();
        resetn = 1'b0;
        tick();
        check("rst state", 64'(bus.state_o), 64'(DIV_IDLE));
        check("rst ready", 64'(bus.ready_o), 64'd0);
        check("rst result", bus.result_o, 64'd0);
        resetn = 1'b1;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cycles++;
            if (bus.ready_o) break;
        end
        check("rst restart latency", 64'(cycles), 64'd33);
        check("rst restart result", bus.result_o, {32'd1, 32'd142857});

        // Hold start for three cycles in DONE.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold ready", 64'(bus.ready_o), 64'd1);
            check("hold result", bus.result_o, {32'd1, 32'd142857});
        end
        bus.start_i = 1'b0;
        tick();
        check("hold release ready", 64'(bus.ready_o), 64'd0);
        check("hold release state", 64'(bus.state_o), 64'(DIV_IDLE));

        // Back-to-back with the minimum one-cycle gap.
        run_div("b2b_div", ALU_DIV, 32'd1000, 32'hFFFF_FFFD, {32'd1, 32'hFFFF_FEB3}, 33);
        run_div("b2b_divu", ALU_DIVU, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage for DIV/DIVU.
- Produces the 64-bit {remainder, quotient} pair written to HI/LO.
- Drives the execute-stage divide stall, div_stallE, consumed by the pipeline hazard unit.
- Flushed by the memory-stage exception flush, so a killed DIV never commits.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset; synchronous, active-low.
- start_i  in  1  divide request from the E-stage decode; held high while the E stage is stalled.
- signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- opa_i  in  DATA_W  dividend (rs); sampled only when leaving IDLE.
- opb_i  in  DATA_W  divisor (rt); sampled only when leaving IDLE.
- annul_i  in  1  abort request (exception flush); kills the operation in progress.
- result_o  out  2*DATA_W  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
- ready_o  out  1  result_o valid this cycle.
- stall_o  out  1  becomes div_stallE = start_i & ~ready_o (combinational).

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=IDLE, cnt=0, working regs=0, result_o=0, ready_o=0.
  - Reset dominates every other input, including mid-operation.
- States: IDLE, BYZERO, BUSY, DONE (encoding in the package).
- IDLE:
  - start_i=1, annul_i=0 and opb_i==0 -> BYZERO.
  - start_i=1, annul_i=0 and opb_i!=0 -> BUSY.
  - Entering BUSY latches the operands:
    - If signed_i=1, latch |opa_i| and |opb_i| as unsigned magnitudes.
    - Latch the signs: qneg = opa[31]^opb[31], rneg = opa[31]; both forced to 0 when signed_i=0.
    - cnt=0; partial remainder=0.
  - Otherwise remain in IDLE.
- BYZERO: next state DONE with result 0 (defined behaviour; the ISA leaves divide-by-zero UNPREDICTABLE).
- BUSY:
  - Each cycle: shift {rem, quo} left by 1, then trial-subtract the divisor from rem.
  - Trial result non-negative: keep the difference and set quo bit 0 = 1. Otherwise restore and set quo bit 0 = 0.
  - cnt increments each cycle. When cnt==DATA_W-1 (32nd iteration) -> DONE.
  - On that transition, apply the signs: quotient negated if qneg, remainder negated if rneg. The result is registered into result_o.
- DONE:
  - ready_o=1 and result_o stable.
  - start_i=0 -> IDLE next cycle; ready_o=0 and result_o cleared to 0.
  - start_i=1 -> stay in DONE (E stage still stalled by another source).
  - A new divide therefore needs at least one cycle with start_i low.
- Latency: start_i rises at edge 0 -> ready_o=1 after edge 33 (32 BUSY cycles + DONE). Divide-by-zero -> ready_o=1 after edge 2.
- Stall: stall_o=1 from the first start_i cycle until ready_o rises, so E holds stable operands.
- annul_i:
  - In BYZERO or BUSY -> IDLE next cycle, ready_o stays 0, result_o not updated.
  - In IDLE it blocks the start.
  - In DONE it forces IDLE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (natural wrap, no trap).
- Arithmetic: magnitudes are DATA_W-bit unsigned; the trial subtract is DATA_W+1 bits wide to capture the borrow.

Decomposition:
- A shared pipeline package holds:
  - the state encoding constants DIV_IDLE, DIV_BYZERO, DIV_BUSY, DIV_DONE;
  - DATA_W;
  - the ALU op codes for DIV/DIVU used by the decoder to drive start_i/signed_i.
- One natural sub-module: div_step, the combinational single-iteration shift/trial-subtract, instantiated once inside the sequential FSM.

Test Plan:
- DIVU 100 / 7, start held until ready -> ready_o=1 exactly 33 cycles after start; result_o = {32'd2, 32'd14}; stall_o=1 for those 33 cycles and 0 once ready_o=1.
- DIV -7 / 2 (0xFFFFFFF9 / 2) -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. DIVU on the same operands -> {32'd1, 32'h7FFFFFFC}.
- DIV 0x80000000 / 0xFFFFFFFF -> {32'h0, 32'h80000000}. DIVU 5 / 0 -> ready_o at cycle 2, result_o=0.
- annul_i pulsed at BUSY cycle 10 of 0x12345678 / 3 -> IDLE next cycle, ready_o never rises, result_o stays 0. A subsequent DIVU 9 / 3 -> {32'd0, 32'd3}.
- resetn=0 for one edge at BUSY cycle 20 -> IDLE, result_o=0, ready_o=0. With start_i still high, the divide restarts and completes 33 cycles after reset release.
- start_i kept high 3 cycles after DONE -> ready_o and result_o hold steady; start_i low -> ready_o=0 the next cycle. Back-to-back divides with a one-cycle gap both return correct results.
